// File: rtl/cnn_pkg.sv
`default_nettype none
// cnn_pkg: shared sample type, pooling FSM states and address-width helper.
// Rev 1.0
package cnn_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD0    = 3'd1,
    S_RD1    = 3'd2,
    S_RD2    = 3'd3,
    S_RD3    = 3'd4,
    S_LAST   = 3'd5,
    S_WRITE  = 3'd6,
    S_FINISH = 3'd7
  } pool_state_t;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_addr_gen.sv
`default_nettype none
// pool_addr_gen: channel/row/column/tap counters for 2x2 stride-2 pooling.
// Rev 1.0
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IN_H     = 28,
  parameter int IN_W     = 28,
  localparam int OH      = IN_H / 2,
  localparam int OW      = IN_W / 2,
  localparam int IN_AW   = addr_width(CHANNELS * IN_H * IN_W),
  localparam int OUT_AW  = addr_width(CHANNELS * OH * OW),
  localparam int CW      = addr_width(CHANNELS),
  localparam int RW      = addr_width(OH),
  localparam int KW      = addr_width(OW)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tap_step,
  input  logic              pix_step,
  output logic [IN_AW-1:0]  tap_addr,
  output logic [OUT_AW-1:0] pix_addr,
  output logic              last_pix
);

  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [KW-1:0] k;
  logic [1:0]    tap;

  logic last_c, last_r, last_k;

  assign last_c   = (c == CW'(CHANNELS - 1));
  assign last_r   = (r == RW'(OH - 1));
  assign last_k   = (k == KW'(OW - 1));
  assign last_pix = last_c && last_r && last_k;

  // Tap bit 1 selects the lower row of the window, bit 0 the right column.
  assign tap_addr = IN_AW'(c) * IN_AW'(IN_H * IN_W)
                  + IN_AW'({r, tap[1]}) * IN_AW'(IN_W)
                  + IN_AW'({k, tap[0]});

  assign pix_addr = OUT_AW'(c) * OUT_AW'(OH * OW)
                  + OUT_AW'(r) * OUT_AW'(OW)
                  + OUT_AW'(k);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c   <= '0;
      r   <= '0;
      k   <= '0;
      tap <= '0;
    end else begin
      if (tap_step) tap <= tap + 2'd1;
      if (pix_step) begin
        if (last_k) begin
          k <= '0;
          if (last_r) begin
            r <= '0;
            c <= last_c ? '0 : c + CW'(1);
          end else begin
            r <= r + RW'(1);
          end
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maxpool2x2_flatten.sv
`default_nettype none
// maxpool2x2_flatten: 2x2/2 signed max-pool with optional ReLU, BRAM to BRAM.
// Rev 1.0
module maxpool2x2_flatten
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28,
  parameter int APPLY_RELU = 0,
  localparam int IN_AW     = addr_width(CHANNELS * IN_H * IN_W),
  localparam int OUT_AW    = addr_width(CHANNELS * (IN_H / 2) * (IN_W / 2))
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic [IN_AW-1:0]             in_addr,
  output logic                         in_en,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  output logic [OUT_AW-1:0]            out_addr,
  output logic                         out_we,
  output logic signed [DATA_WIDTH-1:0] out_d,
  output logic                         busy,
  output logic                         done
);

  if (IN_H % 2 != 0 || IN_W % 2 != 0 || CHANNELS == 0 || IN_H == 0 || IN_W == 0)
  begin : g_bad_geometry
    $fatal(1, "maxpool2x2_flatten: CHANNELS/IN_H/IN_W must be nonzero, IN_H/IN_W even");
  end

  pool_state_t state, next_state;

  logic [IN_AW-1:0]             tap_addr;
  logic [OUT_AW-1:0]            pix_addr;
  logic                         last_pix;
  logic                         final_pix;
  logic                         issue;
  logic signed [DATA_WIDTH-1:0] run_max;
  logic signed [DATA_WIDTH-1:0] pooled;

  pool_addr_gen #(
    .CHANNELS (CHANNELS),
    .IN_H     (IN_H),
    .IN_W     (IN_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .tap_step (issue),
    .pix_step (state == S_LAST),
    .tap_addr (tap_addr),
    .pix_addr (pix_addr),
    .last_pix (last_pix)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_RD0;
      S_RD0:    next_state = S_RD1;
      S_RD1:    next_state = S_RD2;
      S_RD2:    next_state = S_RD3;
      S_RD3:    next_state = S_LAST;
      S_LAST:   next_state = S_WRITE;
      S_WRITE:  next_state = final_pix ? S_FINISH : S_RD0;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign issue = (next_state == S_RD0) || (next_state == S_RD1) ||
                 (next_state == S_RD2) || (next_state == S_RD3);

  // The fourth tap arrives in LAST and is folded in on the way to out_d.
  always_comb begin
    pooled = (in_q > run_max) ? in_q : run_max;
    if (APPLY_RELU != 0 && pooled[DATA_WIDTH-1]) pooled = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_addr   <= '0;
      in_en     <= 1'b0;
      out_addr  <= '0;
      out_we    <= 1'b0;
      out_d     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      run_max   <= '0;
      final_pix <= 1'b0;
    end else begin
      state  <= next_state;
      in_en  <= issue;
      out_we <= (state == S_LAST);
      done   <= (next_state == S_FINISH);
      busy   <= (next_state != S_IDLE) && (next_state != S_FINISH);
      if (issue) in_addr <= tap_addr;
      case (state)
        S_RD1: run_max <= in_q;
        S_RD2, S_RD3: if (in_q > run_max) run_max <= in_q;
        S_LAST: begin
          out_d     <= pooled;
          out_addr  <= pix_addr;
          final_pix <= last_pix;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
